adc_init_seq: RTL and testbench



---
 rtl/adc_init_pkg.sv | 39 +++
 rtl/adc_init_rom.sv | 20 ++
 rtl/adc_init_seq.sv | 185 ++++++++++++++++++
 tb/tb_adc_init_seq.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_init_pkg.sv
// Shared types and constants for the ADC init sequencer: state codes, register-table entry, default table.
// No logic here; latency n/a.
// Backpressure n/a.
package adc_init_pkg;

    localparam logic [3:0] ST_IDLE        = 4'd0;
    localparam logic [3:0] ST_RST_ASSERT  = 4'd1;
    localparam logic [3:0] ST_RST_WAIT    = 4'd2;
    localparam logic [3:0] ST_CFG_REQ     = 4'd3;
    localparam logic [3:0] ST_CFG_WAIT    = 4'd4;
    localparam logic [3:0] ST_SYNC        = 4'd5;
    localparam logic [3:0] ST_LOCK_WAIT   = 4'd6;
    localparam logic [3:0] ST_TRAIN_WAIT  = 4'd7;
    localparam logic [3:0] ST_DONE        = 4'd8;
    localparam logic [3:0] ST_FAIL        = 4'd9;
    localparam logic [3:0] ST_CFG_RD_REQ  = 4'd10;
    localparam logic [3:0] ST_CFG_RD_WAIT = 4'd11;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
        logic [15:0] mask;
    } adc_reg_t;

    localparam int ADC_N_REGS = 8;

    // mask bits set to 1 are compared on readback; entry 0 is a self-clearing soft reset
    localparam adc_reg_t ADC_INIT_TABLE [ADC_N_REGS] = '{
        '{addr: 8'h00, data: 16'h0081, mask: 16'h0000},
        '{addr: 8'h08, data: 16'h0003, mask: 16'h00FF},
        '{addr: 8'h14, data: 16'h0011, mask: 16'hFFFF},
        '{addr: 8'h15, data: 16'h0A20, mask: 16'hFFFF},
        '{addr: 8'h16, data: 16'h0005, mask: 16'h000F},
        '{addr: 8'h21, data: 16'h1200, mask: 16'hFF00},
        '{addr: 8'h28, data: 16'h00C0, mask: 16'hFFFF},
        '{addr: 8'h42, data: 16'h8001, mask: 16'hFFFF}
    };

endpackage

// File: rtl/adc_init_rom.sv
// Register-table lookup: idx in, table entry out (zero beyond the table).
// Purely combinational, zero latency.
// No backpressure.
module adc_init_rom
    import adc_init_pkg::*;
(
    input  logic [7:0] idx,
    output adc_reg_t   entry
);

    always_comb begin
        entry = '0;
        for (int i = 0; i < ADC_N_REGS; i++) begin
            if (idx == 8'(i)) begin
                entry = ADC_INIT_TABLE[i];
            end
        end
    end

endmodule

// File: rtl/adc_init_seq.sv
// ADC power-up sequencer: reset pulse, SPI register load, sync pulse, lock/training wait, retries.
// Async status inputs see 2 cycles of synchroniser latency; ADC_INIT_READBACK_EN adds per-register readback.
// SPI request held until spi_ack; start aborts from any state.
module adc_init_seq
    import adc_init_pkg::*;
#(
    parameter int unsigned RST_CYCLES      = 10,
    parameter int unsigned RST_WAIT_CYCLES = 100,
    parameter int unsigned SYNC_CYCLES     = 4,
    parameter int unsigned LOCK_TIMEOUT    = 10000,
    parameter int unsigned TRAIN_TIMEOUT   = 1000000,
    parameter int unsigned MAX_RETRY       = 3,
    parameter int unsigned N_REGS          = ADC_N_REGS
) (
    input  logic        gclk10m_buf,
    input  logic        sys_rst_n,
    input  logic        start,
    output logic        spi_req,
    output logic        spi_rw,
    output logic [7:0]  spi_addr,
    output logic [15:0] spi_data,
    input  logic        spi_ack,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data,
    output logic        adc_rst,
    output logic        adc_sync,
    input  logic        clk_data_locked,
    input  logic        train_done,
    input  logic        train_error,
    output logic        init_done,
    output logic        init_error,
    output logic [1:0]  retry_cnt,
    output logic [3:0]  seq_state
);

    localparam logic [19:0] RST_LAST   = 20'(RST_CYCLES - 1);
    localparam logic [19:0] WAIT_LAST  = 20'(RST_WAIT_CYCLES - 1);
    localparam logic [19:0] SYNC_LAST  = 20'(SYNC_CYCLES - 1);
    localparam logic [19:0] LOCK_LAST  = 20'(LOCK_TIMEOUT - 1);
    localparam logic [19:0] TRAIN_LAST = 20'(TRAIN_TIMEOUT - 1);
    localparam logic [19:0] CNT_MAX    = '1;
    localparam logic [8:0]  IDX_LAST   = 9'(N_REGS - 1);
    localparam logic [1:0]  RETRY_MAX  = 2'(MAX_RETRY);

    logic [3:0]  state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [8:0]  idx_q, idx_d;
    logic [1:0]  retry_q, retry_d;
    logic [2:0]  meta_q, meta_d, sync_q, sync_d;
    logic        lock_s, tdone_s, terr_s;
    logic        wr_done, ent_done, retry_ev;
    adc_reg_t    rom_entry;

    adc_init_rom u_rom (
        .idx   (idx_q[7:0]),
        .entry (rom_entry)
    );

    assign meta_d  = {train_error, train_done, clk_data_locked};
    assign sync_d  = meta_q;
    assign lock_s  = sync_q[0];
    assign tdone_s = sync_q[1];
    assign terr_s  = sync_q[2];

`ifdef ADC_INIT_READBACK_EN
    logic rd_done, rd_bad;
    assign rd_bad  = |((spi_rd_data ^ rom_entry.data) & rom_entry.mask);
    assign spi_req = (state_q == ST_CFG_REQ) || (state_q == ST_CFG_RD_REQ);
    assign spi_rw  = (state_q == ST_CFG_RD_REQ);
`else
    logic unused_rd;
    assign unused_rd = ^{spi_rd_data, rom_entry.mask};
    assign spi_req   = (state_q == ST_CFG_REQ);
    assign spi_rw    = 1'b0;
`endif

    assign spi_addr   = spi_req ? rom_entry.addr : '0;
    assign spi_data   = (state_q == ST_CFG_REQ) ? rom_entry.data : '0;
    assign adc_rst    = (state_q == ST_RST_ASSERT);
    assign adc_sync   = (state_q == ST_SYNC);
    assign init_done  = (state_q == ST_DONE);
    assign init_error = (state_q == ST_FAIL);
    assign retry_cnt  = retry_q;
    assign seq_state  = state_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 20'd1;
        idx_d    = idx_q;
        retry_d  = retry_q;
        wr_done  = 1'b0;
        ent_done = 1'b0;
        retry_ev = 1'b0;
`ifdef ADC_INIT_READBACK_EN
        rd_done  = 1'b0;
`endif
        case (state_q)
            ST_IDLE:       cnt_d = '0;
            ST_RST_ASSERT: if (cnt_q >= RST_LAST) begin
                               state_d = ST_RST_WAIT;
                               cnt_d   = '0;
                           end
            ST_RST_WAIT:   if (cnt_q >= WAIT_LAST) begin
                               state_d = ST_CFG_REQ;
                               idx_d   = '0;
                           end
            // done coinciding with ack completes the transfer in one step
            ST_CFG_REQ:    if (spi_ack) begin
                               if (spi_done) wr_done = 1'b1;
                               else          state_d = ST_CFG_WAIT;
                           end
            ST_CFG_WAIT:   wr_done = spi_done;
`ifdef ADC_INIT_READBACK_EN
            ST_CFG_RD_REQ: if (spi_ack) begin
                               if (spi_done) rd_done = 1'b1;
                               else          state_d = ST_CFG_RD_WAIT;
                           end
            ST_CFG_RD_WAIT: rd_done = spi_done;
`endif
            ST_SYNC:       if (cnt_q >= SYNC_LAST) begin
                               state_d = ST_LOCK_WAIT;
                               cnt_d   = '0;
                           end
            ST_LOCK_WAIT:  if (lock_s) begin
                               state_d = ST_TRAIN_WAIT;
                               cnt_d   = '0;
                           end else if (cnt_q >= LOCK_LAST) begin
                               retry_ev = 1'b1;
                           end
            // error has priority over a simultaneous done
            ST_TRAIN_WAIT: if (terr_s || cnt_q >= TRAIN_LAST) retry_ev = 1'b1;
                           else if (tdone_s)                  state_d  = ST_DONE;
            ST_DONE:       retry_ev = !lock_s;
            ST_FAIL:       state_d = ST_FAIL;
            default:       state_d = ST_IDLE;
        endcase
`ifdef ADC_INIT_READBACK_EN
        if (wr_done) state_d = ST_CFG_RD_REQ;
        if (rd_done) begin
            if (rd_bad) retry_ev = 1'b1;
            else        ent_done = 1'b1;
        end
`else
        ent_done = wr_done;
`endif
        if (ent_done) begin
            idx_d   = idx_q + 9'd1;
            cnt_d   = '0;
            state_d = (idx_q == IDX_LAST) ? ST_SYNC : ST_CFG_REQ;
        end
        if (retry_ev) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 2'd1;
                state_d = ST_RST_ASSERT;
                cnt_d   = '0;
            end else begin
                state_d = ST_FAIL;
            end
        end
        if (start) begin
            retry_d = '0;
            state_d = ST_RST_ASSERT;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge gclk10m_buf or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            retry_q <= '0;
            meta_q  <= '0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            meta_q  <= meta_d;
            sync_q  <= sync_d;
        end
    end

endmodule

// File: tb/tb_adc_init_seq.sv
// Scoreboard bench for adc_init_seq: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_adc_init_seq;

    localparam int EV_SPI = 1, EV_RST = 2, EV_SYNC = 3, EV_LOCKTO = 4, EV_DONE = 5, EV_ERR = 6;

    typedef struct packed {
        logic [3:0]  kind;
        logic [31:0] val;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        spi_req, spi_rw;
    logic [7:0]  spi_addr;
    logic [15:0] spi_data;
    logic        spi_ack = 1'b0, spi_done = 1'b0;
    logic [15:0] spi_rd_data = '0;
    logic        adc_rst, adc_sync;
    logic        lock = 1'b0, train_done = 1'b0, train_error = 1'b0;
    logic        init_done, init_error;
    logic [1:0]  retry_cnt;
    logic [3:0]  seq_state;

    logic [7:0]  t_addr [8] = '{8'h00, 8'h08, 8'h14, 8'h15, 8'h16, 8'h21, 8'h28, 8'h42};
    logic [15:0] t_data [8] = '{16'h0081, 16'h0003, 16'h0011, 16'h0A20, 16'h0005, 16'h1200, 16'h00C0, 16'h8001};
    logic [15:0] t_mask [8] = '{16'h0000, 16'h00FF, 16'hFFFF, 16'hFFFF, 16'h000F, 16'hFF00, 16'hFFFF, 16'hFFFF};

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  ack_cnt = 0;
    int  late_at = 0;
    bit  corrupt_pending = 1'b0;

    always #5 clk = ~clk;

    adc_init_seq dut (
        .gclk10m_buf     (clk),
        .sys_rst_n       (rst_n),
        .start           (start),
        .spi_req         (spi_req),
        .spi_rw          (spi_rw),
        .spi_addr        (spi_addr),
        .spi_data        (spi_data),
        .spi_ack         (spi_ack),
        .spi_done        (spi_done),
        .spi_rd_data     (spi_rd_data),
        .adc_rst         (adc_rst),
        .adc_sync        (adc_sync),
        .clk_data_locked (lock),
        .train_done      (train_done),
        .train_error     (train_error),
        .init_done       (init_done),
        .init_error      (init_error),
        .retry_cnt       (retry_cnt),
        .seq_state       (seq_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic void push(input int k, input logic [31:0] v);
        ev_t e;
        e.kind = 4'(k);
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    function automatic void push_attempt(input int n_entries, input bit sync_too);
        push(EV_RST, 10);
        for (int i = 0; i < n_entries; i++) begin
            push(EV_SPI, {7'b0, 1'b0, t_addr[i], t_data[i]});
`ifdef ADC_INIT_READBACK_EN
            push(EV_SPI, {7'b0, 1'b1, t_addr[i], 16'h0000});
`endif
        end
        if (sync_too) push(EV_SYNC, 4);
    endfunction

    task automatic observe(input string what, input int k, input logic [31:0] v);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected %s event: got %h, expected none", what, v);
        end else begin
            e = exp_q.pop_front();
            check({"event kind at ", what}, 32'(k), 32'(e.kind));
            check({what, " value"}, v, e.val);
        end
    endtask

    // monitor: turns DUT output activity into events
    initial begin
        int  rst_w, sync_w, lock_w;
        logic done_p, err_p;
        rst_w = 0; sync_w = 0; lock_w = 0; done_p = 1'b0; err_p = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rst_w = 0; sync_w = 0; lock_w = 0; done_p = 1'b0; err_p = 1'b0;
            end else begin
                if (spi_req && spi_ack) observe("spi", EV_SPI, {7'b0, spi_rw, spi_addr, spi_data});
                if (adc_rst) rst_w++;
                else if (rst_w != 0) begin observe("adc_rst width", EV_RST, 32'(rst_w)); rst_w = 0; end
                if (adc_sync) sync_w++;
                else if (sync_w != 0) begin observe("adc_sync width", EV_SYNC, 32'(sync_w)); sync_w = 0; end
                if (seq_state == 4'd6) lock_w++;
                else begin
                    if (lock_w != 0 && (seq_state == 4'd1 || seq_state == 4'd9))
                        observe("lock timeout", EV_LOCKTO, 32'(lock_w));
                    lock_w = 0;
                end
                if (init_done && !done_p) observe("init_done retry", EV_DONE, {30'b0, retry_cnt});
                if (init_error && !err_p) observe("init_error state/retry", EV_ERR, {26'b0, seq_state, retry_cnt});
                done_p = init_done;
                err_p  = init_error;
            end
        end
    end

    // SPI engine model
    initial begin
        logic       rw;
        logic [7:0] a;
        logic [15:0] rd;
        forever begin
            tick();
            if (rst_n && spi_req) begin
                tick();
                if (!rst_n || !spi_req) continue;
                spi_ack = 1'b1;
                rw = spi_rw;
                a  = spi_addr;
                tick();
                spi_ack = 1'b0;
                ack_cnt++;
                repeat ((ack_cnt == late_at) ? 40 : 4) tick();
                rd = '0;
                for (int i = 0; i < 8; i++)
                    if (t_addr[i] == a) rd = t_data[i] ^ ~t_mask[i];
                if (rw && corrupt_pending && a == t_addr[2]) begin
                    rd = rd ^ 16'h0001;
                    corrupt_pending = 1'b0;
                end
                spi_done    = 1'b1;
                spi_rd_data = rd;
                tick();
                spi_done    = 1'b0;
                spi_rd_data = '0;
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int i;
        i = 0;
        while (seq_state != s && i < budget) begin
            tick();
            i++;
        end
        check({name, " reached state"}, 32'(seq_state), 32'(s));
    endtask

    task automatic wait_drain(input int budget, input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            tick();
            i++;
        end
        check({name, " pending events"}, 32'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    initial begin
        int i;
        // reset state and no self-start
        repeat (3) tick();
        check("reset spi_req", 32'(spi_req), 0);
        check("reset adc_rst", 32'(adc_rst), 0);
        check("reset adc_sync", 32'(adc_sync), 0);
        check("reset init_done", 32'(init_done), 0);
        check("reset init_error", 32'(init_error), 0);
        check("reset retry_cnt", 32'(retry_cnt), 0);
        check("reset spi_addr/data", {8'b0, spi_addr, spi_data}, 0);
        rst_n = 1'b1;
        repeat (20) tick();
        check("idle without start", 32'(seq_state), 0);

        // 1: clean bring-up
        push_attempt(8, 1'b1);
        push(EV_DONE, 0);
        pulse_start();
        repeat (199) tick();
        lock = 1'b1;
        repeat (4800) tick();
        train_done = 1'b1;
        wait_state(4'd8, 2000, "t1 done");
        wait_drain(50, "t1");
        check("t1 init_done", 32'(init_done), 1);
        check("t1 retry_cnt", 32'(retry_cnt), 0);

        // 3: training error on attempt 1, done on attempt 2
        train_done = 1'b0;
        push_attempt(8, 1'b1);
        push_attempt(8, 1'b1);
        push(EV_DONE, 1);
        pulse_start();
        wait_state(4'd7, 1000, "t3 train1");
        train_error = 1'b1;
        repeat (2) tick();
        train_error = 1'b0;
        wait_state(4'd1, 20, "t3 retry");
        wait_state(4'd7, 1000, "t3 train2");
        train_done = 1'b1;
        wait_state(4'd8, 20, "t3 done");
        wait_drain(50, "t3");
        check("t3 retry_cnt", 32'(retry_cnt), 1);

        // 5: lock loss in DONE
        push_attempt(8, 1'b1);
        push(EV_DONE, 0);
        pulse_start();
        wait_state(4'd8, 1000, "t5 done1");
        wait_drain(20, "t5 first");
        push_attempt(8, 1'b1);
        push(EV_DONE, 1);
        lock = 1'b0;
        tick();
        check("t5 init_done +1", 32'(init_done), 1);
        tick();
        check("t5 init_done +2", 32'(init_done), 1);
        tick();
        check("t5 init_done +3", 32'(init_done), 0);
        check("t5 state after loss", 32'(seq_state), 1);
        check("t5 retry after loss", 32'(retry_cnt), 1);
        lock = 1'b1;
        wait_state(4'd8, 1000, "t5 done2");
        wait_drain(20, "t5");
        check("t5 retry_cnt", 32'(retry_cnt), 1);

        // 4: abort during CFG_WAIT at idx 3 with a late spi_done
        push_attempt(4, 1'b0);
        push_attempt(8, 1'b1);
        push(EV_DONE, 0);
        late_at = ack_cnt + 4;
        pulse_start();
        i = 0;
        while (ack_cnt < late_at && i < 1000) begin tick(); i++; end
        check("t4 fourth write acked", 32'(ack_cnt), 32'(late_at));
        repeat (2) tick();
        check("t4 in CFG_WAIT", 32'(seq_state), 4);
        pulse_start();
        check("t4 abort state", 32'(seq_state), 1);
        check("t4 abort spi_req", 32'(spi_req), 0);
        wait_state(4'd8, 1000, "t4 done");
        wait_drain(20, "t4");
        check("t4 retry_cnt", 32'(retry_cnt), 0);

        // 2: lock never arrives
        lock = 1'b0;
        train_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_attempt(8, 1'b1);
            push(EV_LOCKTO, 10000);
        end
        push(EV_ERR, {26'b0, 4'd9, 2'd3});
        pulse_start();
        wait_state(4'd9, 45000, "t2 fail");
        wait_drain(20, "t2");
        repeat (20) tick();
        check("t2 stays in FAIL", 32'(seq_state), 9);
        check("t2 init_error", 32'(init_error), 1);
        check("t2 retry_cnt", 32'(retry_cnt), 3);

        // async reset mid-sequence
        lock = 1'b1;
        train_done = 1'b1;
        push(EV_RST, 10);
        pulse_start();
        wait_state(4'd3, 300, "rst cfg");
        #2 rst_n = 1'b0;
        #1;
        check("mid reset spi_req", 32'(spi_req), 0);
        check("mid reset state", 32'(seq_state), 0);
        check("mid reset init_error", 32'(init_error), 0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_drain(5, "mid reset");

`ifdef ADC_INIT_READBACK_EN
        // 6: entry 2 readback corrupted once
        corrupt_pending = 1'b1;
        push_attempt(3, 1'b0);
        push_attempt(8, 1'b1);
        push(EV_DONE, 1);
        pulse_start();
        wait_state(4'd8, 3000, "t6 done");
        wait_drain(20, "t6");
        check("t6 retry_cnt", 32'(retry_cnt), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
